// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM match path: default geometry, width helpers,
// the resolver state encoding and a saturating increment.
package tcam_pkg;

    localparam int unsigned DEF_DATA_BITS = 10;
    localparam int unsigned DEF_FRAGMENTS = 5;
    localparam int unsigned DEF_FRAG_BITS = 3;
    localparam int unsigned DEF_IDWID     = 2;
    localparam int unsigned DEF_MASKWID   = 5;

    localparam int unsigned DEF_KWID    = DEF_DATA_BITS;
    localparam int unsigned DEF_PRIOWID = DEF_IDWID;
    localparam int unsigned DEF_CNTWID  = DEF_IDWID + 1;
    localparam int unsigned DEF_FW      = DEF_DATA_BITS / DEF_FRAGMENTS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic int unsigned frag_width(input int unsigned data_bits,
                                               input int unsigned fragments);
        return data_bits / fragments;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned idwid);
        return idwid + 1;
    endfunction

    // Increment v, clamping at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/key_mask_compare.sv
// Combinational fragment-wise key compare; a fragment whose mask bit is set
// is treated as don't-care.
module key_mask_compare
    import tcam_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned FRAGMENTS = DEF_FRAGMENTS,
    parameter int unsigned MASKWID   = DEF_MASKWID
) (
    input  logic [DATA_BITS-1:0] search_key,
    input  logic [DATA_BITS-1:0] confirm_key,
    input  logic [MASKWID-1:0]   maskid,
    output logic                 match
);

    localparam int unsigned FW = frag_width(DATA_BITS, FRAGMENTS);

    always_comb begin
        match = 1'b1;
        for (int unsigned f = 0; f < FRAGMENTS; f++) begin
            if (!maskid[f] && (search_key[f*FW +: FW] != confirm_key[f*FW +: FW])) begin
                match = 1'b0;
            end
        end
    end

endmodule

// File: rtl/priority_resolver.sv
// Collects ID-update candidates for one search, keeps the lowest-priority hit and
// match count, and presents a registered result held under valid/ready.
module priority_resolver
    import tcam_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned FRAGMENTS = DEF_FRAGMENTS,
    parameter int unsigned FRAG_BITS = DEF_FRAG_BITS,
    parameter int unsigned IDWID     = DEF_IDWID,
    parameter int unsigned MASKWID   = DEF_MASKWID
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_search_start,
    input  logic [DATA_BITS-1:0] i_search_key,
    input  logic                 i_id_update,
    input  logic [IDWID-1:0]     i_id,
    input  logic [MASKWID-1:0]   i_maskid,
    input  logic [DATA_BITS-1:0] i_confirm_key,
    input  logic [IDWID-1:0]     i_priority,
    input  logic                 i_mask_complete,
    input  logic                 i_result_ready,
    output logic                 o_busy,
    output logic                 o_result_valid,
    output logic                 o_hit,
    output logic [IDWID-1:0]     o_match_id,
    output logic [IDWID-1:0]     o_match_priority,
    output logic [IDWID:0]       o_match_count
);

    localparam int unsigned KWID    = DATA_BITS;
    localparam int unsigned PRIOWID = IDWID;
    localparam int unsigned CNTWID  = cnt_width(IDWID);

    generate
        if (MASKWID != FRAGMENTS) begin : g_bad_mask
            $error("MASKWID must equal FRAGMENTS");
        end
        if ((DATA_BITS % FRAGMENTS) != 0) begin : g_bad_frag
            $error("FRAGMENTS must divide DATA_BITS");
        end
        if (FRAGMENTS > (1 << FRAG_BITS)) begin : g_bad_frag_bits
            $error("FRAG_BITS too small for FRAGMENTS");
        end
    endgenerate

    state_t               r_state;
    state_t               s_next;
    logic [KWID-1:0]      r_key;
    logic                 r_mc_d;
    logic                 mc_rise;

    logic                 cand_match;
    logic                 r_cand_vld;
    logic                 r_cand_hit;
    logic [IDWID-1:0]     r_cand_id;
    logic [PRIOWID-1:0]   r_cand_prio;

    logic                 r_have_best;
    logic [IDWID-1:0]     r_best_id;
    logic [PRIOWID-1:0]   r_best_prio;
    logic [CNTWID-1:0]    r_count;

    logic                 fold;
    logic                 nxt_have_best;
    logic [IDWID-1:0]     nxt_best_id;
    logic [PRIOWID-1:0]   nxt_best_prio;
    logic [CNTWID-1:0]    nxt_count;

    key_mask_compare #(
        .DATA_BITS (DATA_BITS),
        .FRAGMENTS (FRAGMENTS),
        .MASKWID   (MASKWID)
    ) u_cmp (
        .search_key  (r_key),
        .confirm_key (i_confirm_key),
        .maskid      (i_maskid),
        .match       (cand_match)
    );

    assign mc_rise = i_mask_complete & ~r_mc_d;
    assign o_busy  = (r_state != IDLE);

    always_comb begin
        s_next = r_state;
        case (r_state)
            IDLE:    if (i_search_start) s_next = COLLECT;
            COLLECT: if (mc_rise)        s_next = RESOLVE;
            RESOLVE:                     s_next = DONE;
            DONE:    if (i_result_ready) s_next = IDLE;
            default:                     s_next = IDLE;
        endcase
    end

    // Best/count after folding the staged candidate; RESOLVE captures this directly
    // so the candidate from the mask-complete cycle reaches the result.
    always_comb begin
        fold          = r_cand_vld & r_cand_hit &
                        ((r_state == COLLECT) || (r_state == RESOLVE));
        nxt_have_best = r_have_best;
        nxt_best_id   = r_best_id;
        nxt_best_prio = r_best_prio;
        nxt_count     = r_count;
        if (fold) begin
            nxt_count = CNTWID'(sat_inc(32'(r_count), CNTWID));
            if (!r_have_best || (r_cand_prio < r_best_prio)) begin
                nxt_have_best = 1'b1;
                nxt_best_id   = r_cand_id;
                nxt_best_prio = r_cand_prio;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_key            <= '0;
            r_mc_d           <= 1'b0;
            r_cand_vld       <= 1'b0;
            r_cand_hit       <= 1'b0;
            r_cand_id        <= '0;
            r_cand_prio      <= '0;
            r_have_best      <= 1'b0;
            r_best_id        <= '0;
            r_best_prio      <= '0;
            r_count          <= '0;
            o_result_valid   <= 1'b0;
            o_hit            <= 1'b0;
            o_match_id       <= '0;
            o_match_priority <= '0;
            o_match_count    <= '0;
        end else begin
            r_state     <= s_next;
            r_mc_d      <= i_mask_complete;
            r_cand_vld  <= i_id_update & (r_state == COLLECT);
            r_cand_hit  <= cand_match;
            r_cand_id   <= i_id;
            r_cand_prio <= i_priority;

            if ((r_state == IDLE) && i_search_start) begin
                r_key       <= i_search_key;
                r_have_best <= 1'b0;
                r_best_id   <= '0;
                r_best_prio <= '0;
                r_count     <= '0;
            end else begin
                r_have_best <= nxt_have_best;
                r_best_id   <= nxt_best_id;
                r_best_prio <= nxt_best_prio;
                r_count     <= nxt_count;
            end

            if (r_state == RESOLVE) begin
                o_result_valid   <= 1'b1;
                o_hit            <= nxt_have_best;
                o_match_id       <= nxt_have_best ? nxt_best_id : '0;
                o_match_priority <= nxt_have_best ? nxt_best_prio : '0;
                o_match_count    <= nxt_count;
            end else if ((r_state == DONE) && i_result_ready) begin
                o_result_valid   <= 1'b0;
                o_hit            <= 1'b0;
                o_match_id       <= '0;
                o_match_priority <= '0;
                o_match_count    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_priority_resolver.sv
// Directed bench for priority_resolver: hits, misses, ties, saturation,
// handshake hold, same-cycle rise update, level-high entry and mid-search reset.
module tb_priority_resolver;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_search_start;
    logic [9:0] i_search_key;
    logic       i_id_update;
    logic [1:0] i_id;
    logic [4:0] i_maskid;
    logic [9:0] i_confirm_key;
    logic [1:0] i_priority;
    logic       i_mask_complete;
    logic       i_result_ready;
    logic       o_busy;
    logic       o_result_valid;
    logic       o_hit;
    logic [1:0] o_match_id;
    logic [1:0] o_match_priority;
    logic [2:0] o_match_count;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    priority_resolver #(
        .DATA_BITS (10),
        .FRAGMENTS (5),
        .FRAG_BITS (3),
        .IDWID     (2),
        .MASKWID   (5)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i_search_start   (i_search_start),
        .i_search_key     (i_search_key),
        .i_id_update      (i_id_update),
        .i_id             (i_id),
        .i_maskid         (i_maskid),
        .i_confirm_key    (i_confirm_key),
        .i_priority       (i_priority),
        .i_mask_complete  (i_mask_complete),
        .i_result_ready   (i_result_ready),
        .o_busy           (o_busy),
        .o_result_valid   (o_result_valid),
        .o_hit            (o_hit),
        .o_match_id       (o_match_id),
        .o_match_priority (o_match_priority),
        .o_match_count    (o_match_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic v, input logic h,
                                input logic [1:0] id, input logic [1:0] pr,
                                input logic [2:0] cnt);
        check({tag, ".valid"}, 32'(o_result_valid), 32'(v));
        check({tag, ".hit"},   32'(o_hit), 32'(h));
        check({tag, ".id"},    32'(o_match_id), 32'(id));
        check({tag, ".prio"},  32'(o_match_priority), 32'(pr));
        check({tag, ".count"}, 32'(o_match_count), 32'(cnt));
    endtask

    task automatic start_search(input logic [9:0] key);
        i_search_start = 1'b1;
        i_search_key   = key;
        tick();
        i_search_start = 1'b0;
    endtask

    task automatic upd(input logic [1:0] id, input logic [9:0] conf,
                       input logic [4:0] mask, input logic [1:0] prio);
        i_id_update   = 1'b1;
        i_id          = id;
        i_confirm_key = conf;
        i_maskid      = mask;
        i_priority    = prio;
        tick();
        i_id_update   = 1'b0;
    endtask

    // Raise mask_complete; result must appear exactly two edges later.
    task automatic finish_search(input string tag);
        i_mask_complete = 1'b1;
        tick();
        check({tag, ".lat1"}, 32'(o_result_valid), 32'd0);
        tick();
        check({tag, ".lat2"}, 32'(o_result_valid), 32'd1);
    endtask

    task automatic accept();
        i_result_ready = 1'b1;
        tick();
        i_result_ready  = 1'b0;
        i_mask_complete = 1'b0;
        check("accept.valid", 32'(o_result_valid), 32'd0);
        check("accept.busy",  32'(o_busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        i_search_start = 1'b0;  i_search_key = '0;
        i_id_update = 1'b0;     i_id = '0;       i_maskid = '0;
        i_confirm_key = '0;     i_priority = '0;
        i_mask_complete = 1'b0; i_result_ready = 1'b0;
        tick();
        tick();
        check_result("reset", 1'b0, 1'b0, 2'd0, 2'd0, 3'd0);
        check("reset.busy", 32'(o_busy), 32'd0);
        reset = 1'b0;
        tick();

        // Two hits; fragment 0 masked on the second, which has better priority
        start_search(10'h2B5);
        check("two.busy", 32'(o_busy), 32'd1);
        upd(2'd1, 10'h2B5, 5'b00000, 2'd2);
        upd(2'd2, 10'h2B4, 5'b00001, 2'd1);
        finish_search("two");
        check_result("two", 1'b1, 1'b1, 2'd2, 2'd1, 3'd2);

        // Hold: ready low for 5 cycles, result stable
        for (int i = 0; i < 5; i++) begin
            tick();
            check_result("hold", 1'b1, 1'b1, 2'd2, 2'd1, 3'd2);
        end
        // search_start coincident with the handshake is ignored
        i_search_start = 1'b1;
        i_search_key   = 10'h000;
        accept();
        i_search_start = 1'b0;
        check_result("cleared", 1'b0, 1'b0, 2'd0, 2'd0, 3'd0);
        tick();
        check("ign_start.busy", 32'(o_busy), 32'd0);

        // No hit: fragment 4 differs and nothing masked
        start_search(10'h2B5);
        upd(2'd3, 10'h0B5, 5'b00000, 2'd0);
        finish_search("nohit");
        check_result("nohit", 1'b1, 1'b0, 2'd0, 2'd0, 3'd0);
        accept();

        // Nine equal-priority hits: earliest id wins, count saturates
        start_search(10'h155);
        for (int i = 0; i < 9; i++) begin
            upd(2'((i + 3) % 4), 10'h155, 5'b00000, 2'd3);
        end
        finish_search("sat");
        check_result("sat", 1'b1, 1'b1, 2'd3, 2'd3, 3'd7);
        accept();

        // Update in the rise cycle is counted and wins
        start_search(10'h3FF);
        upd(2'd2, 10'h3FF, 5'b00000, 2'd2);
        i_id_update = 1'b1; i_id = 2'd1; i_confirm_key = 10'h000;
        i_maskid = 5'b11111; i_priority = 2'd0;
        finish_search("same");
        i_id_update = 1'b0;
        check_result("same", 1'b1, 1'b1, 2'd1, 2'd0, 3'd2);
        accept();

        // mask_complete already high on entry does not end the search
        i_mask_complete = 1'b1;
        tick();
        start_search(10'h0F0);
        tick();
        tick();
        check("level.busy",  32'(o_busy), 32'd1);
        check("level.valid", 32'(o_result_valid), 32'd0);
        upd(2'd0, 10'h0F3, 5'b00001, 2'd1);
        i_mask_complete = 1'b0;
        tick();
        finish_search("level");
        check_result("level", 1'b1, 1'b1, 2'd0, 2'd1, 3'd1);
        accept();

        // Reset mid-collect after two hits
        start_search(10'h2B5);
        upd(2'd1, 10'h2B5, 5'b00000, 2'd2);
        upd(2'd2, 10'h2B5, 5'b00000, 2'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst.busy", 32'(o_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst.valid", 32'(o_result_valid), 32'd0);
        end
        // update while idle is ignored
        upd(2'd3, 10'h2B5, 5'b00000, 2'd0);
        start_search(10'h2B5);
        tick();
        finish_search("empty");
        check_result("empty", 1'b1, 1'b0, 2'd0, 2'd0, 3'd0);
        accept();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
